multicycle_control: RTL and testbench

- Multi-cycle LEGv8 control unit: a state machine that sequences each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives per-cycle datapath enables, plus req/ack handshakes to instruction and data memory.
- Sits between the instruction register and the shared multi-cycle datapath (single ALU, single PC adder).
- Adds wait-state tolerance, a memory timeout and a retired-instruction counter.

---
 rtl/multicycle_control.sv | 166 ++++++++++++++++
 tb/tb_multicycle_control.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// LEGv8 multi-cycle control FSM: req/ack memory handshakes, wait-state timeout, retired counter.
// Optional macro ILLEGAL_TRAP_EN: illegal opcodes lock into TRAP instead of retiring as a NOP.
module multicycle_control #(
  parameter int OPCODE_W = 11,
  parameter int ALU_OP_W = 2,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                imem_ack,
  input  logic                dmem_ack,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic                readreg2_control,
  output logic                alu_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                retire,
  output logic                mem_timeout,
  output logic                illegal_op,
  output logic [CNT_W-1:0]    retired_cnt
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

  localparam logic [15:0] WAIT_LAST = 16'(WAIT_MAX - 1);

  state_t              state;
  logic [OPCODE_W-1:0] op_q;
  logic [15:0]         wait_cnt;
  logic [10:0]         op11;
  logic                is_r, is_ld, is_st, is_cbz, is_cbnz, is_b, illegal;
  logic                waiting, timeout_hit, taken;

  // DECODE sees the opcode as it is latched; later states use the latched copy.
  assign op11 = 11'((state == DECODE) ? opcode : op_q);

  assign is_r    = (op11 == 11'b10001011000) || (op11 == 11'b11001011000) ||
                   (op11 == 11'b10001010000) || (op11 == 11'b10101010000);
  assign is_ld   = (op11 == 11'b11111000010);
  assign is_st   = (op11 == 11'b11111000000);
  assign is_cbz  = (op11[10:3] == 8'b10110100);
  assign is_cbnz = (op11[10:3] == 8'b10110101);
  assign is_b    = (op11[10:5] == 6'b000101);
  assign illegal = !(is_r || is_ld || is_st || is_cbz || is_cbnz || is_b);

  assign waiting     = ((state == FETCH) && !imem_ack) || ((state == MEM) && !dmem_ack);
  assign timeout_hit = waiting && (wait_cnt == WAIT_LAST);
  assign taken       = is_b || (is_cbz && zero) || (is_cbnz && !zero);

  always_comb begin
    imem_req         = 1'b0;
    dmem_req         = 1'b0;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    pc_src           = 1'b0;
    readreg2_control = 1'b0;
    alu_src          = 1'b0;
    alu_op           = '0;
    reg_write        = 1'b0;
    mem_to_reg       = 1'b0;
    retire           = 1'b0;
    mem_timeout      = 1'b0;
    illegal_op       = 1'b0;
    // Outputs are forced low for as long as reset is held.
    if (reset_n) begin
      case (state)
        FETCH: begin
          imem_req    = 1'b1;
          ir_write    = imem_ack;
          pc_write    = imem_ack;
          mem_timeout = timeout_hit;
        end
        DECODE: begin
          readreg2_control = is_st || is_cbz || is_cbnz;
          illegal_op       = illegal;
`ifndef ILLEGAL_TRAP_EN
          retire           = illegal;
`endif
        end
        EXEC: begin
          if (is_r) begin
            alu_op = ALU_OP_W'(2'b10);
          end else if (is_ld || is_st) begin
            alu_src = 1'b1;
          end else begin
            alu_op           = ALU_OP_W'(2'b01);
            readreg2_control = is_cbz || is_cbnz;
            pc_write         = taken;
            pc_src           = taken;
            retire           = 1'b1;
          end
        end
        MEM: begin
          dmem_req    = 1'b1;
          mem_read    = is_ld;
          mem_write   = is_st;
          mem_timeout = timeout_hit;
          retire      = dmem_ack && is_st;
        end
        WB: begin
          reg_write  = 1'b1;
          mem_to_reg = is_ld;
          retire     = 1'b1;
        end
        TRAP: illegal_op = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FETCH;
      op_q        <= '0;
      wait_cnt    <= '0;
      retired_cnt <= '0;
    end else begin
      if (retire) retired_cnt <= retired_cnt + CNT_W'(1);
      // Any state change clears the wait counter; only unacked request cycles advance it.
      wait_cnt <= '0;
      case (state)
        FETCH: begin
          if (imem_ack)          state    <= DECODE;
          else if (!timeout_hit) wait_cnt <= wait_cnt + 16'd1;
        end
        DECODE: begin
          op_q <= opcode;
          if (illegal)
`ifdef ILLEGAL_TRAP_EN
            state <= TRAP;
`else
            state <= FETCH;
`endif
          else
            state <= EXEC;
        end
        EXEC: begin
          if (is_ld || is_st) state <= MEM;
          else if (is_r)      state <= WB;
          else                state <= FETCH;
        end
        MEM: begin
          if (dmem_ack)         state    <= is_ld ? WB : FETCH;
          else if (timeout_hit) state    <= FETCH;
          else                  wait_cnt <= wait_cnt + 16'd1;
        end
        WB:      state <= FETCH;
        TRAP:    state <= TRAP;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: each instruction is expanded into its expected
// cycle-by-cycle waveform from the opcode class, ack delays and zero flag, then replayed and compared.
module tb_multicycle_control;

  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 4;
  localparam int C_R = 0, C_LD = 1, C_ST = 2, C_CBZ = 3, C_CBNZ = 4, C_B = 5, C_ILL = 6;

  localparam logic [10:0] OP_ADD = 11'b10001011000, OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000, OP_ORR = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010, OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ = 11'b10110100101, OP_CBNZ = 11'b10110101011;
  localparam logic [10:0] OP_B = 11'b00010110110;

  typedef struct packed {
    logic       imem_req, dmem_req, mem_read, mem_write, ir_write, pc_write, pc_src;
    logic       readreg2_control, alu_src;
    logic [1:0] alu_op;
    logic       reg_write, mem_to_reg, retire, mem_timeout, illegal_op;
  } outs_t;

  typedef struct {
    logic        rst_n, iack, dack, zero;
    logic [10:0] op;
    outs_t       exp;
    logic [CNT_W-1:0] cnt;
    int          tag, idx;
  } cyc_t;

  logic clk = 1'b0, reset_n = 1'b0;
  logic [10:0] opcode = '0;
  logic zero = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
  logic imem_req, dmem_req, mem_read, mem_write, ir_write, pc_write, pc_src;
  logic readreg2_control, alu_src, reg_write, mem_to_reg, retire, mem_timeout, illegal_op;
  logic [1:0] alu_op;
  logic [CNT_W-1:0] retired_cnt;

  cyc_t sched[$];
  cyc_t cur;
  logic active = 1'b0;
  int   exp_cnt = 0;
  int   n_cmp = 0, n_bad = 0;
  int   retire_at[64], req_cycles[64], to_at[64];

  always #5 clk = ~clk;

  multicycle_control #(.OPCODE_W(11), .ALU_OP_W(2), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .readreg2_control(readreg2_control), .alu_src(alu_src), .alu_op(alu_op),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .retire(retire),
    .mem_timeout(mem_timeout), .illegal_op(illegal_op), .retired_cnt(retired_cnt)
  );

  function automatic int cls(input logic [10:0] op);
    if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) return C_R;
    if (op == OP_LDUR)              return C_LD;
    if (op == OP_STUR)              return C_ST;
    if (op ==? 11'b10110100???)     return C_CBZ;
    if (op ==? 11'b10110101???)     return C_CBNZ;
    if (op ==? 11'b000101?????)     return C_B;
    return C_ILL;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [10:0] rop();
    return 11'($urandom);
  endfunction

  function automatic void push(input logic r, input logic ia, input logic da, input logic z,
                               input logic [10:0] op, input outs_t e, input int tag, input int idx);
    cyc_t c;
    c.rst_n = r; c.iack = ia; c.dack = da; c.zero = z; c.op = op; c.exp = e;
    c.cnt = r ? CNT_W'(exp_cnt) : '0;
    c.tag = tag; c.idx = idx;
    sched.push_back(c);
    if (!r)            exp_cnt = 0;
    else if (e.retire) exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
  endfunction

  function automatic void plan_reset(input int n);
    outs_t e;
    e = '0;
    for (int i = 0; i < n; i++) push(1'b0, rb(), rb(), rb(), rop(), e, 0, 0);
  endfunction

  // fd/md: unacked cycles before the ack; abort_mem >= 0 cuts the instruction after that many MEM cycles.
  function automatic void plan_instr(input logic [10:0] op, input int fd, input int md,
                                     input logic z, input int abort_mem, input int tag);
    outs_t e;
    int idx, w, k;
    logic tk;
    idx = 0; w = 0; k = cls(op);
    for (int i = 0; i <= fd; i++) begin
      e = '0; e.imem_req = 1'b1;
      if (i == fd) begin
        e.ir_write = 1'b1; e.pc_write = 1'b1;
      end else begin
        w++;
        if (w == WAIT_MAX) begin e.mem_timeout = 1'b1; w = 0; end
      end
      idx++; push(1'b1, i == fd, rb(), rb(), rop(), e, tag, idx);
    end
    e = '0;
    e.readreg2_control = (k == C_ST || k == C_CBZ || k == C_CBNZ);
    if (k == C_ILL) begin
      e.illegal_op = 1'b1;
`ifndef ILLEGAL_TRAP_EN
      e.retire = 1'b1;
`endif
    end
    idx++; push(1'b1, rb(), rb(), rb(), op, e, tag, idx);
    if (k == C_ILL) begin
`ifdef ILLEGAL_TRAP_EN
      e = '0; e.illegal_op = 1'b1;
      for (int i = 0; i < 20; i++) begin idx++; push(1'b1, rb(), rb(), rb(), rop(), e, tag, idx); end
`endif
      return;
    end
    e = '0;
    case (k)
      C_R:          e.alu_op = 2'b10;
      C_LD, C_ST:   e.alu_src = 1'b1;
      C_CBZ, C_CBNZ: begin e.alu_op = 2'b01; e.readreg2_control = 1'b1; end
      default:      e.alu_op = 2'b01;
    endcase
    if (k >= C_CBZ) begin
      tk = (k == C_B) || (k == C_CBZ && z) || (k == C_CBNZ && !z);
      e.pc_write = tk; e.pc_src = tk; e.retire = 1'b1;
    end
    idx++; push(1'b1, rb(), rb(), z, rop(), e, tag, idx);
    if (k >= C_CBZ) return;
    if (k == C_LD || k == C_ST) begin
      w = 0;
      for (int i = 0; i <= md; i++) begin
        if (i == abort_mem) return;
        e = '0; e.dmem_req = 1'b1; e.mem_read = (k == C_LD); e.mem_write = (k == C_ST);
        if (i == md) e.retire = (k == C_ST);
        else begin w++; if (w == WAIT_MAX) e.mem_timeout = 1'b1; end
        idx++; push(1'b1, rb(), i == md, rb(), rop(), e, tag, idx);
        if (e.mem_timeout || e.retire) return;
      end
    end
    e = '0; e.reg_write = 1'b1; e.mem_to_reg = (k == C_LD); e.retire = 1'b1;
    idx++; push(1'b1, rb(), rb(), rb(), rop(), e, tag, idx);
  endfunction

  function automatic logic [10:0] pick_illegal();
    logic [10:0] op;
    for (int t = 0; t < 16; t++) begin
      op = rop();
      if (cls(op) == C_ILL) return op;
    end
    return 11'd0;
  endfunction

  function automatic int pick_delay();
    int r;
    r = $urandom_range(0, 99);
    if (r < 70) return 0;
    if (r < 95) return $urandom_range(1, WAIT_MAX - 1);
    return $urandom_range(WAIT_MAX, WAIT_MAX + 5);
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    outs_t a;
    if (active) begin
      a = {imem_req, dmem_req, mem_read, mem_write, ir_write, pc_write, pc_src,
           readreg2_control, alu_src, alu_op, reg_write, mem_to_reg, retire,
           mem_timeout, illegal_op};
      n_cmp++;
      if (a !== cur.exp) begin
        n_bad++;
        $display("FAIL outputs t=%0t tag=%0d cyc=%0d actual=%b required=%b", $time, cur.tag, cur.idx, a, cur.exp);
      end
      n_cmp++;
      if (retired_cnt !== cur.cnt) begin
        n_bad++;
        $display("FAIL retired_cnt t=%0t tag=%0d cyc=%0d actual=%0d required=%0d", $time, cur.tag, cur.idx, retired_cnt, cur.cnt);
      end
      if (cur.tag > 0 && cur.tag < 64) begin
        if (retire === 1'b1)      retire_at[cur.tag] = cur.idx;
        if (dmem_req === 1'b1)    req_cycles[cur.tag]++;
        if (mem_timeout === 1'b1) to_at[cur.tag] = cur.idx;
      end
    end
  end

  initial begin
    logic [10:0] op;
    int ab;
    plan_reset(3);
    plan_instr(OP_ADD,  0, 0, 1'b0, -1, 1);
    plan_instr(OP_LDUR, 0, 3, 1'b0, -1, 2);
    plan_instr(OP_CBZ,  0, 0, 1'b1, -1, 3);
    plan_instr(OP_CBNZ, 0, 0, 1'b1, -1, 4);
    plan_instr(OP_STUR, 0, WAIT_MAX + 5, 1'b0, -1, 5);
`ifndef ILLEGAL_TRAP_EN
    plan_instr(11'd0, 0, 0, 1'b0, -1, 6);
`endif
    plan_instr(OP_LDUR, 0, 20, 1'b0, 2, 7);
    plan_reset(2);
    plan_instr(OP_ADD,  0, 0, 1'b0, -1, 8);
    plan_instr(OP_B,    WAIT_MAX - 1, 0, 1'b0, -1, 9);
    plan_instr(OP_ORR,  WAIT_MAX + 3, 0, 1'b0, -1, 10);

    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 8))
        0: op = OP_ADD;
        1: op = OP_SUB;
        2: op = OP_AND;
        3: op = OP_ORR;
        4: op = OP_LDUR;
        5: op = OP_STUR;
        6: op = {8'b10110100, 3'($urandom)};
        7: op = {8'b10110101, 3'($urandom)};
        default: op = {6'b000101, 5'($urandom)};
      endcase
`ifndef ILLEGAL_TRAP_EN
      if ($urandom_range(0, 9) == 0) op = pick_illegal();
`endif
      ab = ($urandom_range(0, 99) < 4) ? $urandom_range(0, 3) : -1;
      plan_instr(op, pick_delay(), pick_delay(), rb(), ab, 100 + n);
      if (ab >= 0) plan_reset($urandom_range(1, 2));
    end

`ifdef ILLEGAL_TRAP_EN
    plan_instr(11'd0, 0, 0, 1'b0, -1, 6);
    plan_reset(2);
    plan_instr(OP_ADD, 0, 0, 1'b0, -1, 11);
`endif

    while (sched.size() > 0) begin
      @(posedge clk);
      #1;
      cur      = sched.pop_front();
      reset_n  = cur.rst_n;
      imem_ack = cur.iack;
      dmem_ack = cur.dack;
      zero     = cur.zero;
      opcode   = cur.op;
      active   = 1'b1;
    end
    @(posedge clk);
    #1 active = 1'b0;

    chk("add_retire_cycle",    retire_at[1], 4);
    chk("ldur_retire_cycle",   retire_at[2], 8);
    chk("ldur_dmem_req_cycles", req_cycles[2], 4);
    chk("cbz_retire_cycle",    retire_at[3], 3);
    chk("cbnz_retire_cycle",   retire_at[4], 3);
    chk("stur_timeout_cycle",  to_at[5], 18);
    chk("stur_no_retire",      retire_at[5], 0);
`ifdef ILLEGAL_TRAP_EN
    chk("illegal_trap_no_retire", retire_at[6], 0);
    chk("add_after_trap_retire",  retire_at[11], 4);
`else
    chk("illegal_nop_retire",  retire_at[6], 2);
`endif
    chk("ldur_abort_no_retire", retire_at[7], 0);
    chk("add_after_reset_retire", retire_at[8], 4);
    chk("b_slow_fetch_retire", retire_at[9], WAIT_MAX + 2);
    chk("orr_fetch_timeout_cycle", to_at[10], WAIT_MAX);
    chk("orr_after_timeout_retire", retire_at[10], WAIT_MAX + 3 + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
